// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register file and its reorder-buffer link.
package register_file_pkg;

    localparam int unsigned ROB_WIDTH_BIT = 4;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_ID_W      = 5;
    localparam int unsigned NUM_REGS      = 32;

endpackage

// File: rtl/register_file_if.sv
// Register-file bus: commit/rename from the reorder buffer, operand lookups from the decoder.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_BIT
);
    logic                 clear;
    logic [REG_ID_W-1:0]  set_reg_id;
    logic [XLEN-1:0]      set_val;
    logic [ROB_WIDTH-1:0] set_reg_on_rob_id;
    logic [REG_ID_W-1:0]  set_dep_reg_id;
    logic [ROB_WIDTH-1:0] set_dep_rob_id;

    logic [REG_ID_W-1:0]  rs1_id;
    logic [REG_ID_W-1:0]  rs2_id;
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic                 rs1_has_dep;
    logic                 rs2_has_dep;
    logic [ROB_WIDTH-1:0] rs1_dep;
    logic [ROB_WIDTH-1:0] rs2_dep;

    logic [ROB_WIDTH-1:0] get_rob_id1;
    logic [ROB_WIDTH-1:0] get_rob_id2;
    logic                 rob_value1_ready;
    logic                 rob_value2_ready;
    logic [XLEN-1:0]      rob_value1;
    logic [XLEN-1:0]      rob_value2;

    modport master (
        output clear, set_reg_id, set_val, set_reg_on_rob_id, set_dep_reg_id, set_dep_rob_id,
        output rs1_id, rs2_id, rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
        input  rs1_val, rs2_val, rs1_has_dep, rs2_has_dep, rs1_dep, rs2_dep,
        input  get_rob_id1, get_rob_id2
    );

    modport slave (
        input  clear, set_reg_id, set_val, set_reg_on_rob_id, set_dep_reg_id, set_dep_rob_id,
        input  rs1_id, rs2_id, rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
        output rs1_val, rs2_val, rs1_has_dep, rs2_has_dep, rs1_dep, rs2_dep,
        output get_rob_id1, get_rob_id2
    );

endinterface

// File: rtl/register_file_reg_read_port.sv
// Resolves one source operand: x0, settled register value, or forwarded/outstanding ROB tag.
module reg_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_BIT
) (
    input  logic [REG_ID_W-1:0]  src,
    input  logic                 busy,
    input  logic [ROB_WIDTH-1:0] tag,
    input  logic [XLEN-1:0]      val,
    input  logic                 rob_ready,
    input  logic [XLEN-1:0]      rob_value,
    output logic [XLEN-1:0]      rd_val,
    output logic                 has_dep,
    output logic [ROB_WIDTH-1:0] dep,
    output logic [ROB_WIDTH-1:0] get_rob_id
);

    always_comb begin
        rd_val     = '0;
        has_dep    = 1'b0;
        dep        = '0;
        get_rob_id = '0;
        if (src != '0) begin
            if (!busy) begin
                rd_val = val;
            end else begin
                // A ready ROB entry also covers the same-cycle commit of this producer.
                get_rob_id = tag;
                if (rob_ready) begin
                    rd_val = rob_value;
                end else begin
                    has_dep = 1'b1;
                    dep     = tag;
                end
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags and two forwarding read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_BIT
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    register_file_if.slave  bus
);

    logic [XLEN-1:0]      val_q [NUM_REGS];
    logic [ROB_WIDTH-1:0] tag_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;

    // Commit first, rename second, so a same-cycle rename of the register wins.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (bus.clear) begin
                busy_q <= '0;
            end else begin
                if (bus.set_reg_id != '0) begin
                    val_q[bus.set_reg_id] <= bus.set_val;
                    if (busy_q[bus.set_reg_id] && (tag_q[bus.set_reg_id] == bus.set_reg_on_rob_id)) begin
                        busy_q[bus.set_reg_id] <= 1'b0;
                    end
                end
                if (bus.set_dep_reg_id != '0) begin
                    busy_q[bus.set_dep_reg_id] <= 1'b1;
                    tag_q[bus.set_dep_reg_id]  <= bus.set_dep_rob_id;
                end
            end
        end
    end

    reg_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs1 (
        .src        (bus.rs1_id),
        .busy       (busy_q[bus.rs1_id]),
        .tag        (tag_q[bus.rs1_id]),
        .val        (val_q[bus.rs1_id]),
        .rob_ready  (bus.rob_value1_ready),
        .rob_value  (bus.rob_value1),
        .rd_val     (bus.rs1_val),
        .has_dep    (bus.rs1_has_dep),
        .dep        (bus.rs1_dep),
        .get_rob_id (bus.get_rob_id1)
    );

    reg_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs2 (
        .src        (bus.rs2_id),
        .busy       (busy_q[bus.rs2_id]),
        .tag        (tag_q[bus.rs2_id]),
        .val        (val_q[bus.rs2_id]),
        .rob_ready  (bus.rob_value2_ready),
        .rob_value  (bus.rob_value2),
        .rd_val     (bus.rs2_val),
        .has_dep    (bus.rs2_has_dep),
        .dep        (bus.rs2_dep),
        .get_rob_id (bus.get_rob_id2)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: directed stimulus queues expected lookups, a negedge monitor checks them.
module tb_register_file;
    import register_file_pkg::*;

    localparam int unsigned RW = ROB_WIDTH_BIT;

    typedef struct {
        string          name;
        int             port;
        logic [31:0]    val;
        logic           has_dep;
        logic [RW-1:0]  dep;
        logic [RW-1:0]  gid;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   checks = 0;
    int   passed = 0;
    exp_t sb_q[$];

    register_file_if #(.ROB_WIDTH(RW)) bus ();

    register_file #(.ROB_WIDTH(RW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Monitor: every queued expectation is compared against the live read outputs.
    always @(negedge clk_in) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.port == 1) begin
                cmp({e.name, ".val1"}, bus.rs1_val, e.val);
                cmp({e.name, ".hd1"},  32'(bus.rs1_has_dep), 32'(e.has_dep));
                cmp({e.name, ".dep1"}, 32'(bus.rs1_dep), 32'(e.dep));
                cmp({e.name, ".gid1"}, 32'(bus.get_rob_id1), 32'(e.gid));
            end else begin
                cmp({e.name, ".val2"}, bus.rs2_val, e.val);
                cmp({e.name, ".hd2"},  32'(bus.rs2_has_dep), 32'(e.has_dep));
                cmp({e.name, ".dep2"}, 32'(bus.rs2_dep), 32'(e.dep));
                cmp({e.name, ".gid2"}, 32'(bus.get_rob_id2), 32'(e.gid));
            end
        end
    end

    task automatic expect_rd(input string nm, input int port, input logic [31:0] v,
                             input logic hd, input int dep, input int gid);
        exp_t e;
        e.name = nm; e.port = port; e.val = v; e.has_dep = hd;
        e.dep = RW'(dep); e.gid = RW'(gid);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1;
        bus.clear = 1'b0;
        bus.set_reg_id = '0; bus.set_val = '0; bus.set_reg_on_rob_id = '0;
        bus.set_dep_reg_id = '0; bus.set_dep_rob_id = '0;
        bus.rob_value1_ready = 1'b0; bus.rob_value2_ready = 1'b0;
        bus.rob_value1 = '0; bus.rob_value2 = '0;
    endtask

    task automatic commit(input int r, input int tag, input logic [31:0] v);
        bus.set_reg_id = 5'(r); bus.set_reg_on_rob_id = RW'(tag); bus.set_val = v;
    endtask

    task automatic rename(input int r, input int tag);
        bus.set_dep_reg_id = 5'(r); bus.set_dep_rob_id = RW'(tag);
    endtask

    task automatic reads(input int a, input int b);
        bus.rs1_id = 5'(a); bus.rs2_id = 5'(b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reads(0, 0);
        rst_in = 1'b0;
        tick(); tick();
        rst_in = 1'b1;

        // Out of reset everything reads zero.
        reads(5, 0);
        expect_rd("reset_x5", 1, 32'h0, 1'b0, 0, 0);
        expect_rd("reset_x0", 2, 32'h0, 1'b0, 0, 0);
        tick();

        // Rename x3 -> tag 4; the same-cycle read must not see it.
        rename(3, 4);
        reads(3, 0);
        expect_rd("rename_same_cycle", 1, 32'h0, 1'b0, 0, 0);
        tick(); idle();
        reads(3, 3);
        bus.rob_value1 = 32'hDEAD;
        expect_rd("x3_outstanding", 1, 32'h0, 1'b1, 4, 4);
        expect_rd("x3_outstanding_p2", 2, 32'h0, 1'b1, 4, 4);
        tick();
        bus.rob_value1_ready = 1'b1;
        expect_rd("x3_forward", 1, 32'hDEAD, 1'b0, 0, 4);
        tick(); idle();

        // Commit and rename x7 in one cycle: rename wins, val still written.
        rename(7, 2);
        tick();
        commit(7, 2, 32'h11);
        rename(7, 5);
        tick(); idle();
        reads(7, 0);
        expect_rd("x7_renamed", 1, 32'h0, 1'b1, 5, 5);
        tick();
        bus.clear = 1'b1;
        tick(); idle();
        expect_rd("x7_val_kept", 1, 32'h11, 1'b0, 0, 0);
        tick();

        // Stale commit on x9 updates value only; matching commit releases it.
        rename(9, 6);
        tick(); idle();
        commit(9, 1, 32'h22);
        tick(); idle();
        reads(9, 0);
        expect_rd("x9_stale_commit", 1, 32'h0, 1'b1, 6, 6);
        tick();
        commit(9, 6, 32'h33);
        bus.rob_value1_ready = 1'b1;
        bus.rob_value1 = 32'h33;
        expect_rd("x9_bypass", 1, 32'h33, 1'b0, 0, 6);
        tick(); idle();
        expect_rd("x9_committed", 1, 32'h33, 1'b0, 0, 0);
        tick();

        // Flush discards commit and rename on the squashed path.
        commit(4, 0, 32'h44);
        tick(); idle();
        rename(4, 3);
        tick(); idle();
        bus.clear = 1'b1;
        commit(4, 3, 32'h99);
        rename(8, 7);
        tick(); idle();
        reads(4, 8);
        expect_rd("x4_after_clear", 1, 32'h44, 1'b0, 0, 0);
        expect_rd("x8_rename_dropped", 2, 32'h0, 1'b0, 0, 0);
        tick();

        // x0 is never written or renamed.
        commit(0, 5, 32'h55);
        rename(0, 5);
        tick(); idle();
        reads(0, 0);
        bus.rob_value1_ready = 1'b1;
        bus.rob_value1 = 32'h1234;
        expect_rd("x0_val", 1, 32'h0, 1'b0, 0, 0);
        expect_rd("x0_val_p2", 2, 32'h0, 1'b0, 0, 0);
        tick(); idle();

        // rdy_in low freezes state, reads stay live.
        rdy_in = 1'b0;
        commit(5, 0, 32'hAB);
        rename(6, 1);
        reads(4, 0);
        expect_rd("stall_read_live", 1, 32'h44, 1'b0, 0, 0);
        tick(); idle();
        reads(5, 6);
        expect_rd("stall_no_commit", 1, 32'h0, 1'b0, 0, 0);
        expect_rd("stall_no_rename", 2, 32'h0, 1'b0, 0, 0);
        tick();

        // Maximum tag value round-trips.
        rename(10, 15);
        tick(); idle();
        reads(10, 10);
        expect_rd("x10_max_tag", 2, 32'h0, 1'b1, 15, 15);
        tick();

        // Reset overrides rdy_in low and clear.
        rst_in = 1'b0;
        rdy_in = 1'b0;
        bus.clear = 1'b1;
        tick();
        rst_in = 1'b1;
        idle();
        reads(4, 10);
        expect_rd("x4_reset", 1, 32'h0, 1'b0, 0, 0);
        expect_rd("x10_reset", 2, 32'h0, 1'b0, 0, 0);
        tick();

        @(negedge clk_in);
        @(negedge clk_in);
        checks++;
        if (sb_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
